dram_port_arbiter: RTL and testbench
====================================

// Module: dram_port_arbiter
// PURPOSE
//  N-channel arbiter multiplexing independent requesters (instr fetch, load/store, display, DMA) onto the single
//  SDRAM read/write port pair. Replaces per-state ad-hoc muxing of dram_rd_*/dram_wr_* inside the core controller.
//  One transaction in flight at a time; round-robin fairness; optional per-transaction timeout with error report.
// PARAMETERS
//  NCH      4   number of requester channels (2..8)
//  AW       32  address width
//  DW       32  data width
//  TIMEOUT  0   max cycles waiting for dram_*_fin before abort; 0 = never abort
// PORTS
//  clk           in   1       clock; all logic on posedge
//  reset         in   1       synchronous, active-low reset (sampled at posedge clk, 0 = reset)
//  ch_req        in   NCH     per-channel request level; held until matching ch_fin pulse
//  ch_we         in   NCH     1 = write, 0 = read; sampled with ch_req at grant
//  ch_addr       in   NCH*AW  flattened; channel i at [i*AW +: AW]
//  ch_wdata      in   NCH*DW  flattened; channel i at [i*DW +: DW]
//  ch_fin        out  NCH     one-cycle completion pulse, one-hot
//  ch_err        out  1       valid with ch_fin: transaction aborted by timeout
//  ch_rdata      out  DW      read data, valid in the ch_fin cycle (shared across channels)
//  grant_id      out  $clog2(NCH)  channel currently owning the port
//  busy          out  1       high from grant until DONE exits
//  dram_rd_req/dram_wr_req   out  1   level request to SDRAM controller
//  dram_rd_addr/dram_wr_addr out  AW
//  dram_wr_data  out  DW
//  dram_rd_fin/dram_wr_fin   in   1   completion pulse from SDRAM controller
//  dram_rd_data  in   DW      valid with dram_rd_fin
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr_last = NCH-1 (ch0 wins first contention), timeout counter 0.
//  FSM IDLE -> WAIT -> DONE -> IDLE.
//  IDLE: if any ch_req, pick winner = first set bit searching rr_last+1 .. wrapping; same edge: latch addr/data/we,
//   assert dram_rd_req or dram_wr_req, grant_id <= winner, busy <= 1, rr_last <= winner -> WAIT. 1-cycle grant latency.
//  WAIT: hold dram req/addr/data stable. On matching dram_*_fin: drop dram req, ch_fin[grant_id] <= 1,
//   ch_rdata <= dram_rd_data (reads; writes leave ch_rdata unchanged), ch_err <= 0 -> DONE.
//   fin of the non-matching direction, or any fin in IDLE/DONE, is ignored.
//   ch_req deassert while in WAIT is ignored; transaction completes normally.
//  Timeout (TIMEOUT>0): counter clears on entry to WAIT, increments each WAIT cycle; when it reaches TIMEOUT
//   with no fin: drop dram req, ch_fin pulse with ch_err=1, ch_rdata unchanged -> DONE.
//   fin arriving the same cycle the counter reaches TIMEOUT wins: normal completion, ch_err=0.
//  DONE: ch_fin/ch_err <= 0, busy <= 0 -> IDLE. Requests ignored for this cycle so the served channel can drop
//   ch_req; a channel still holding req re-enters arbitration in IDLE as a new transaction.
//  Back-to-back: one idle-bus cycle (DONE) minimum between transactions; 3 cycles + SDRAM latency per access.
//  Fairness: with all NCH requesting continuously, grants rotate 0,1,..,NCH-1,0,...
//  Reset asserted mid-WAIT: transaction dropped, no ch_fin issued; requester must re-request after reset.
// CONFIGURATION
//  DRAM_ARB_FIXED_PRIO_EN defined: round-robin replaced by fixed priority, lowest index wins; rr_last unused.
//  Undefined: round-robin as above.
// STRUCTURE
//  Package dram_arb_pkg: state encodings (ARB_IDLE, ARB_WAIT, ARB_DONE), NCH_MAX=8, clog2 helper function.
//  Sub-module dram_arb_pick: combinational winner select (req vector, rr_last) -> (valid, index); holds both
//  round-robin and DRAM_ARB_FIXED_PRIO_EN variants. Top holds FSM, latches, timeout counter.
// TESTING
//  Single read: ch1 req rd addr 0x100, SDRAM fin after 5 cyc with 0xDEADBEEF -> ch_fin=0b0010, ch_rdata=0xDEADBEEF.
//  Single write: ch2 we addr 0x200 data 0x12345678 -> dram_wr_* stable until fin; ch_fin=0b0100, ch_err=0.
//  Contention: ch0..3 all req continuously, 8 txns -> grant order 0,1,2,3,0,1,2,3 (fixed-prio build: all ch0).
//  Timeout: TIMEOUT=16, SDRAM never fins -> dram req drops after 16 WAIT cycles; ch_fin+ch_err=1.
//  Race: fin on exactly cycle 16 with TIMEOUT=16 -> ch_err=0, data captured.
//  Reset low mid-WAIT -> all outputs 0 next edge, no ch_fin; after release ch0 granted first.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// -----------------------------------------------------------------------------
// dram_arb_pkg
//   Shared definitions for the DRAM port arbiter:
//     - FSM state encodings (ARB_IDLE, ARB_WAIT, ARB_DONE)
//     - NCH_MAX : the largest supported requester count
//     - clog2() : index/counter width helper (never returns less than 1 bit)
// -----------------------------------------------------------------------------
package dram_arb_pkg;

    localparam int NCH_MAX = 8;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_WAIT = 2'd1;
    localparam logic [1:0] ARB_DONE = 2'd2;

    // Ceiling log2, clamped to 1 so that it can size a vector even for value <= 2.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dram_port_arbiter_if
//   The SDRAM-side read/write port pair that the arbiter drives.
//   master : arbiter side (drives requests, address, write data)
//   slave  : SDRAM controller side (drives completion pulses, read data)
//   Signals:
//     dram_rd_req / dram_wr_req     level requests
//     dram_rd_addr / dram_wr_addr   request addresses (AW bits)
//     dram_wr_data                  write data (DW bits)
//     dram_rd_fin / dram_wr_fin     one-cycle completion pulses
//     dram_rd_data                  read data, valid with dram_rd_fin
// -----------------------------------------------------------------------------
interface dram_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          dram_rd_req;
    logic          dram_wr_req;
    logic [AW-1:0] dram_rd_addr;
    logic [AW-1:0] dram_wr_addr;
    logic [DW-1:0] dram_wr_data;
    logic          dram_rd_fin;
    logic          dram_wr_fin;
    logic [DW-1:0] dram_rd_data;

    modport master (
        output dram_rd_req, dram_wr_req, dram_rd_addr, dram_wr_addr, dram_wr_data,
        input  dram_rd_fin, dram_wr_fin, dram_rd_data
    );

    modport slave (
        input  dram_rd_req, dram_wr_req, dram_rd_addr, dram_wr_addr, dram_wr_data,
        output dram_rd_fin, dram_wr_fin, dram_rd_data
    );
endinterface

// File: rtl/dram_arb_pick.sv
// -----------------------------------------------------------------------------
// dram_arb_pick
//   Combinational winner select for the DRAM port arbiter.
//   Ports:
//     req     in  NCH  request vector
//     rr_last in  IW   last granted channel (round-robin pointer)
//     valid   out 1    at least one request present
//     idx     out IW   winning channel index
//   Build option DRAM_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins and
//   rr_last is ignored. Default: round-robin, search starts at rr_last+1 and wraps.
// -----------------------------------------------------------------------------
module dram_arb_pick
    import dram_arb_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  rr_last,
    output logic           valid,
    output logic [IW-1:0]  idx
);

`ifdef DRAM_ARB_FIXED_PRIO_EN
    logic rr_unused;
    assign rr_unused = ^rr_last;

    // Descending scan: the last hit written is the lowest requesting index.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] cand;

    // Scan offsets from farthest to nearest so the closest requester after
    // rr_last overwrites any earlier hit.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int off = NCH; off >= 1; off--) begin
            cand = IW'((int'(rr_last) + off) % NCH);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end
`endif

endmodule

// File: rtl/dram_port_arbiter.sv
// -----------------------------------------------------------------------------
// dram_port_arbiter
//   Multiplexes NCH independent requesters onto one SDRAM read/write port pair.
//   One transaction in flight; IDLE -> WAIT -> DONE -> IDLE. Optional timeout
//   (TIMEOUT > 0) aborts a transaction that receives no completion.
//   Build option DRAM_ARB_FIXED_PRIO_EN: fixed priority instead of round-robin.
//   Ports:
//     clk, reset            clock; synchronous active-low reset
//     ch_req/ch_we          per-channel request level and direction
//     ch_addr/ch_wdata      flattened per-channel address / write data
//     ch_fin/ch_err         one-hot completion pulse, abort flag valid with it
//     ch_rdata              read data, valid in the ch_fin cycle
//     grant_id/busy         current owner, transaction in progress
//     dram                  SDRAM port (dram_port_arbiter_if.master)
// -----------------------------------------------------------------------------
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         ch_req,
    input  logic [NCH-1:0]         ch_we,
    input  logic [NCH*AW-1:0]      ch_addr,
    input  logic [NCH*DW-1:0]      ch_wdata,
    output logic [NCH-1:0]         ch_fin,
    output logic                   ch_err,
    output logic [DW-1:0]          ch_rdata,
    output logic [clog2(NCH)-1:0]  grant_id,
    output logic                   busy,
    dram_port_arbiter_if.master    dram
);

    localparam int IW = clog2(NCH);
    localparam int CW = clog2(TIMEOUT + 1);
    // Counter value seen in the last WAIT cycle allowed before an abort.
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [1:0]     state_q,   state_d;
    logic [IW-1:0]  rr_last_q, rr_last_d;
    logic [IW-1:0]  grant_q,   grant_d;
    logic           we_q,      we_d;
    logic [AW-1:0]  addr_q,    addr_d;
    logic [DW-1:0]  wdata_q,   wdata_d;
    logic           rd_req_q,  rd_req_d;
    logic           wr_req_q,  wr_req_d;
    logic           busy_q,    busy_d;
    logic [NCH-1:0] fin_q,     fin_d;
    logic           err_q,     err_d;
    logic [DW-1:0]  rdata_q,   rdata_d;
    logic [CW-1:0]  cnt_q,     cnt_d;

    logic           pick_valid;
    logic [IW-1:0]  pick_idx;
    logic           fin_match;
    logic           timeout_hit;

    dram_arb_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .req     (ch_req),
        .rr_last (rr_last_q),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    // Only the completion of the direction actually requested counts.
    assign fin_match   = we_q ? dram.dram_wr_fin : dram.dram_rd_fin;
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        grant_d   = grant_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_req_d  = rd_req_q;
        wr_req_d  = wr_req_q;
        busy_d    = busy_q;
        fin_d     = fin_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d   = ARB_WAIT;
                    grant_d   = pick_idx;
                    rr_last_d = pick_idx;
                    we_d      = ch_we[pick_idx];
                    addr_d    = ch_addr[pick_idx*AW +: AW];
                    wdata_d   = ch_wdata[pick_idx*DW +: DW];
                    rd_req_d  = !ch_we[pick_idx];
                    wr_req_d  = ch_we[pick_idx];
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                end
            end
            ARB_WAIT: begin
                // A completion in the same cycle the timeout expires still wins.
                if (fin_match) begin
                    state_d        = ARB_DONE;
                    rd_req_d       = 1'b0;
                    wr_req_d       = 1'b0;
                    fin_d          = '0;
                    fin_d[grant_q] = 1'b1;
                    err_d          = 1'b0;
                    if (!we_q) begin
                        rdata_d = dram.dram_rd_data;
                    end
                end else if (timeout_hit) begin
                    state_d        = ARB_DONE;
                    rd_req_d       = 1'b0;
                    wr_req_d       = 1'b0;
                    fin_d          = '0;
                    fin_d[grant_q] = 1'b1;
                    err_d          = 1'b1;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ARB_DONE: begin
                // Requests are not sampled here so the served channel can drop ch_req.
                state_d = ARB_IDLE;
                fin_d   = '0;
                err_d   = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ARB_IDLE;
            rr_last_q <= IW'(NCH - 1);
            grant_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            fin_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            grant_q   <= grant_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_req_q  <= rd_req_d;
            wr_req_q  <= wr_req_d;
            busy_q    <= busy_d;
            fin_q     <= fin_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ch_fin            = fin_q;
    assign ch_err            = err_q;
    assign ch_rdata          = rdata_q;
    assign grant_id          = grant_q;
    assign busy              = busy_q;
    assign dram.dram_rd_req  = rd_req_q;
    assign dram.dram_wr_req  = wr_req_q;
    assign dram.dram_rd_addr = addr_q;
    assign dram.dram_wr_addr = addr_q;
    assign dram.dram_wr_data = wdata_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_port_arbiter
//   Self-checking bench for dram_port_arbiter (NCH=4, TIMEOUT=16). The bench
//   plays the SDRAM controller and the requesters; the expected winner comes
//   from the arbitration rule applied to the current request set, expected
//   read data from a running record of completed reads.
// -----------------------------------------------------------------------------
module tb_dram_port_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 16;

    logic            clk;
    logic            reset;
    logic [NCH-1:0]  ch_req;
    logic [NCH-1:0]  ch_we;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [NCH-1:0]  ch_fin;
    logic            ch_err;
    logic [DW-1:0]   ch_rdata;
    logic [1:0]      grant_id;
    logic            busy;

    dram_port_arbiter_if #(.AW(AW), .DW(DW)) dif ();

    dram_port_arbiter #(
        .NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_we(ch_we),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_fin(ch_fin),
        .ch_err(ch_err), .ch_rdata(ch_rdata), .grant_id(grant_id),
        .busy(busy), .dram(dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state
    int          model_last;
    logic [31:0] model_rdata;
    logic        a_we[NCH];
    logic [31:0] a_addr[NCH];
    logic [31:0] a_wdata[NCH];

    typedef struct {
        bit          got;
        int          wait_cyc;
        logic        busy;
        logic [1:0]  gid;
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          stable;
        int          req_cyc;
        bit          done;
        logic [3:0]  fin;
        logic        err;
        logic [31:0] rdata;
    } obs_t;

    // Arbitration rule: first requester after the last grant, wrapping
    // (fixed-priority build: lowest requesting index).
    function automatic int model_pick(input logic [3:0] req, input int last);
`ifdef DRAM_ARB_FIXED_PRIO_EN
        for (int c = 0; c < NCH; c++)
            if (((req >> c) & 4'd1) != 4'd0) return c;
`else
        for (int off = 1; off <= NCH; off++)
            if (((req >> ((last + off) % NCH)) & 4'd1) != 4'd0) return (last + off) % NCH;
`endif
        return -1;
    endfunction

    task automatic set_ch(input int ch, input logic we, input logic [31:0] addr, input logic [31:0] data);
        a_we[ch]    = we;
        a_addr[ch]  = addr;
        a_wdata[ch] = data;
        ch_we[ch]   = we;
        ch_addr[ch*AW +: AW]  = addr;
        ch_wdata[ch*DW +: DW] = data;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        ch_req = '0;
        dif.dram_rd_fin = 1'b0;
        dif.dram_wr_fin = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_last  = NCH - 1;
        model_rdata = '0;
    endtask

    // Acts as the SDRAM controller for one transaction and records what was seen.
    // lat = WAIT cycle in which the completion pulse is given (if give_fin).
    task automatic serve(input int lat, input bit give_fin, input logic [31:0] rd_val,
                         input bit wrong_pulse, input bit drop_req, output obs_t o);
        o = '{default: 0};
        for (int w = 1; w <= 4 && !o.got; w++) begin
            @(negedge clk);
            if (dif.dram_rd_req || dif.dram_wr_req) begin
                o.got = 1;
                o.wait_cyc = w;
            end
        end
        if (!o.got) return;
        o.busy   = busy;
        o.gid    = grant_id;
        o.is_wr  = dif.dram_wr_req;
        o.addr   = dif.dram_wr_req ? dif.dram_wr_addr : dif.dram_rd_addr;
        o.wdata  = dif.dram_wr_data;
        o.stable = (dif.dram_rd_req != dif.dram_wr_req);
        for (int k = 1; k <= 60; k++) begin
            if (ch_fin != '0) begin
                o.done  = 1;
                o.fin   = ch_fin;
                o.err   = ch_err;
                o.rdata = ch_rdata;
                break;
            end
            if (dif.dram_rd_req || dif.dram_wr_req) begin
                o.req_cyc++;
                if (grant_id !== o.gid || dif.dram_wr_req !== o.is_wr || dif.dram_rd_req !== !o.is_wr ||
                    (o.is_wr ? dif.dram_wr_addr : dif.dram_rd_addr) !== o.addr ||
                    (o.is_wr && dif.dram_wr_data !== o.wdata) || busy !== 1'b1)
                    o.stable = 0;
            end
            if (give_fin && k == lat) begin
                if (o.is_wr) dif.dram_wr_fin = 1'b1;
                else         dif.dram_rd_fin = 1'b1;
                dif.dram_rd_data = rd_val;
            end
            if (wrong_pulse && k == 2) begin
                if (o.is_wr) dif.dram_rd_fin = 1'b1;
                else         dif.dram_wr_fin = 1'b1;
            end
            if (drop_req && k == 2) ch_req = '0;
            @(negedge clk);
            dif.dram_rd_fin  = 1'b0;
            dif.dram_wr_fin  = 1'b0;
            dif.dram_rd_data = $urandom;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ch_fin !== 4'b0) begin errors++; $display("FAIL reset_ch_fin got %b want 0000", ch_fin); end
        checks++; if (ch_err !== 1'b0) begin errors++; $display("FAIL reset_ch_err got %b want 0", ch_err); end
        checks++; if (ch_rdata !== 32'h0) begin errors++; $display("FAIL reset_ch_rdata got %h want 0", ch_rdata); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if ({dif.dram_rd_req, dif.dram_wr_req} !== 2'b00) begin errors++; $display("FAIL reset_dram_req got %b want 00", {dif.dram_rd_req, dif.dram_wr_req}); end
        checks++; if (dif.dram_rd_addr !== 32'h0 || dif.dram_wr_addr !== 32'h0 || dif.dram_wr_data !== 32'h0) begin
            errors++; $display("FAIL reset_dram_bus got %h/%h/%h want 0", dif.dram_rd_addr, dif.dram_wr_addr, dif.dram_wr_data); end
        reset = 1'b1;
    endtask

    task automatic test_single_read();
        obs_t o;
        set_ch(1, 1'b0, 32'h100, 32'h0);
        ch_req = 4'b0010;
        serve(5, 1, 32'hDEADBEEF, 0, 0, o);
        checks++; if (o.wait_cyc !== 1) begin errors++; $display("FAIL rd_grant_latency got %0d want 1", o.wait_cyc); end
        checks++; if (o.busy !== 1'b1) begin errors++; $display("FAIL rd_busy got %b want 1", o.busy); end
        checks++; if (o.gid !== 2'd1 || o.is_wr !== 1'b0) begin errors++; $display("FAIL rd_grant got id %0d wr %b want id 1 wr 0", o.gid, o.is_wr); end
        checks++; if (o.addr !== 32'h100) begin errors++; $display("FAIL rd_addr got %h want 00000100", o.addr); end
        checks++; if (!o.stable || o.req_cyc !== 5) begin errors++; $display("FAIL rd_hold got stable %0d cycles %0d want 1/5", o.stable, o.req_cyc); end
        checks++; if (o.fin !== 4'b0010 || o.err !== 1'b0) begin errors++; $display("FAIL rd_fin got %b err %b want 0010 err 0", o.fin, o.err); end
        checks++; if (o.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", o.rdata); end
        model_last = 1; model_rdata = 32'hDEADBEEF;
        ch_req = 4'b0000;
        @(negedge clk);
        checks++; if (ch_fin !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_done got fin %b busy %b want 0000/0", ch_fin, busy); end
    endtask

    task automatic test_single_write();
        obs_t o;
        set_ch(2, 1'b1, 32'h200, 32'h12345678);
        ch_req = 4'b0100;
        serve(4, 1, 32'hCAFEF00D, 0, 0, o);
        checks++; if (o.gid !== 2'd2 || o.is_wr !== 1'b1) begin errors++; $display("FAIL wr_grant got id %0d wr %b want id 2 wr 1", o.gid, o.is_wr); end
        checks++; if (o.addr !== 32'h200 || o.wdata !== 32'h12345678) begin errors++; $display("FAIL wr_bus got %h/%h want 00000200/12345678", o.addr, o.wdata); end
        checks++; if (!o.stable || o.req_cyc !== 4) begin errors++; $display("FAIL wr_hold got stable %0d cycles %0d want 1/4", o.stable, o.req_cyc); end
        checks++; if (o.fin !== 4'b0100 || o.err !== 1'b0) begin errors++; $display("FAIL wr_fin got %b err %b want 0100 err 0", o.fin, o.err); end
        checks++; if (o.rdata !== model_rdata) begin errors++; $display("FAIL wr_rdata_kept got %h want %h", o.rdata, model_rdata); end
        model_last = 2;
        ch_req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_contention();
        obs_t o;
        int exp;
        logic [31:0] d;
        apply_reset();
        for (int c = 0; c < NCH; c++) set_ch(c, 1'($urandom_range(0, 1)), $urandom, $urandom);
        ch_req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            exp = model_pick(ch_req, model_last);
            d = $urandom;
            serve($urandom_range(1, 6), 1, d, 0, 0, o);
            checks++; if (o.gid !== 2'(exp) || o.fin !== 4'(1 << exp)) begin
                errors++; $display("FAIL contention_order txn %0d got id %0d fin %b want id %0d", t, o.gid, o.fin, exp); end
            checks++; if (o.addr !== a_addr[exp] || o.is_wr !== a_we[exp]) begin
                errors++; $display("FAIL contention_bus txn %0d got %h wr %b want %h wr %b", t, o.addr, o.is_wr, a_addr[exp], a_we[exp]); end
            if (t > 0) begin
                checks++; if (o.wait_cyc !== 2) begin errors++; $display("FAIL back_to_back txn %0d got gap %0d want 2", t, o.wait_cyc); end
            end
            model_last = exp;
            if (!a_we[exp]) model_rdata = d;
        end
        ch_req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        obs_t o;
        set_ch(3, 1'b0, $urandom, 32'h0);
        ch_req = 4'b1000;
        serve(0, 0, 32'h0, 0, 0, o);
        checks++; if (o.gid !== 2'd3) begin errors++; $display("FAIL to_grant got %0d want 3", o.gid); end
        checks++; if (o.req_cyc !== TO || !o.stable) begin errors++; $display("FAIL to_req_cycles got %0d stable %0d want %0d/1", o.req_cyc, o.stable, TO); end
        checks++; if (o.fin !== 4'b1000 || o.err !== 1'b1) begin errors++; $display("FAIL to_fin got %b err %b want 1000 err 1", o.fin, o.err); end
        checks++; if (o.rdata !== model_rdata) begin errors++; $display("FAIL to_rdata_kept got %h want %h", o.rdata, model_rdata); end
        model_last = 3;
        ch_req = 4'b0000;
        @(negedge clk);
        checks++; if (ch_err !== 1'b0 || ch_fin !== 4'b0) begin errors++; $display("FAIL to_done got err %b fin %b want 0/0000", ch_err, ch_fin); end
    endtask

    task automatic test_race();
        obs_t o;
        logic [31:0] d;
        d = $urandom;
        set_ch(0, 1'b0, $urandom, 32'h0);
        ch_req = 4'b0001;
        serve(TO, 1, d, 0, 0, o);
        checks++; if (o.fin !== 4'b0001 || o.err !== 1'b0) begin errors++; $display("FAIL race_fin got %b err %b want 0001 err 0", o.fin, o.err); end
        checks++; if (o.rdata !== d) begin errors++; $display("FAIL race_data got %h want %h", o.rdata, d); end
        checks++; if (o.req_cyc !== TO) begin errors++; $display("FAIL race_cycles got %0d want %0d", o.req_cyc, TO); end
        model_last = 0; model_rdata = d;
        ch_req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_ignore_fin();
        obs_t o;
        @(negedge clk);
        dif.dram_rd_fin = 1'b1; dif.dram_wr_fin = 1'b1; dif.dram_rd_data = 32'h5A5A5A5A;
        @(negedge clk);
        dif.dram_rd_fin = 1'b0; dif.dram_wr_fin = 1'b0;
        checks++; if (ch_fin !== 4'b0 || busy !== 1'b0 || ch_rdata !== model_rdata) begin
            errors++; $display("FAIL idle_fin_ignored got fin %b busy %b rdata %h want 0000/0/%h", ch_fin, busy, ch_rdata, model_rdata); end
        set_ch(1, 1'b1, 32'hA0, 32'h0BADC0DE);
        ch_req = 4'b0010;
        serve(6, 1, 32'h77777777, 1, 1, o);
        checks++; if (o.req_cyc !== 6 || !o.stable) begin errors++; $display("FAIL wrong_fin_ignored got cycles %0d stable %0d want 6/1", o.req_cyc, o.stable); end
        checks++; if (o.fin !== 4'b0010 || o.err !== 1'b0 || o.rdata !== model_rdata) begin
            errors++; $display("FAIL req_drop_completes got fin %b err %b rdata %h want 0010/0/%h", o.fin, o.err, o.rdata, model_rdata); end
        model_last = 1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        obs_t o;
        set_ch(2, 1'b0, 32'h300, 32'h0);
        set_ch(0, 1'b1, 32'h400, 32'h11112222);
        ch_req = 4'b0100;
        @(negedge clk);
        checks++; if (dif.dram_rd_req !== 1'b1) begin errors++; $display("FAIL midwait_setup got rd_req %b want 1", dif.dram_rd_req); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ch_fin !== 4'b0 || busy !== 1'b0 || dif.dram_rd_req !== 1'b0 || grant_id !== 2'd0 || ch_rdata !== 32'h0) begin
            errors++; $display("FAIL midwait_reset got fin %b busy %b rdreq %b id %0d rdata %h want all 0", ch_fin, busy, dif.dram_rd_req, grant_id, ch_rdata); end
        model_last = NCH - 1; model_rdata = '0;
        ch_req = 4'b0101;
        reset = 1'b1;
        serve(3, 1, 32'h0, 0, 0, o);
        checks++; if (o.gid !== 2'(model_pick(4'b0101, NCH - 1)) || o.fin !== 4'b0001) begin
            errors++; $display("FAIL post_reset_first got id %0d fin %b want id 0", o.gid, o.fin); end
        model_last = 0;
        ch_req = 4'b0100;
        serve(2, 1, 32'h600DF00D, 0, 0, o);
        checks++; if (o.gid !== 2'd2 || o.rdata !== 32'h600DF00D) begin
            errors++; $display("FAIL post_reset_rerequest got id %0d rdata %h want 2/600df00d", o.gid, o.rdata); end
        model_last = 2; model_rdata = 32'h600DF00D;
        ch_req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_random();
        obs_t o;
        int exp, lat, c;
        bit give;
        logic [31:0] d;
        for (int ch = 0; ch < NCH; ch++)
            if ($urandom_range(0, 1) == 1) begin set_ch(ch, 1'($urandom_range(0, 1)), $urandom, $urandom); ch_req[ch] = 1'b1; end
        if (ch_req == '0) begin c = $urandom_range(0, NCH - 1); set_ch(c, 1'b0, $urandom, $urandom); ch_req[c] = 1'b1; end
        for (int t = 0; t < 30; t++) begin
            exp  = model_pick(ch_req, model_last);
            lat  = $urandom_range(1, 20);
            give = (lat <= TO);
            d    = $urandom;
            serve(lat, give, d, 0, 0, o);
            checks++; if (o.gid !== 2'(exp) || o.fin !== 4'(1 << exp)) begin
                errors++; $display("FAIL rand_winner txn %0d got id %0d fin %b want id %0d", t, o.gid, o.fin, exp); end
            checks++; if (o.is_wr !== a_we[exp] || o.addr !== a_addr[exp] || (a_we[exp] && o.wdata !== a_wdata[exp]) || !o.stable) begin
                errors++; $display("FAIL rand_bus txn %0d got wr %b addr %h data %h stable %0d want wr %b addr %h data %h", t, o.is_wr, o.addr, o.wdata, o.stable, a_we[exp], a_addr[exp], a_wdata[exp]); end
            if (give && !a_we[exp]) model_rdata = d;
            checks++; if (o.err !== !give || o.rdata !== model_rdata) begin
                errors++; $display("FAIL rand_result txn %0d got err %b rdata %h want err %b rdata %h", t, o.err, o.rdata, !give, model_rdata); end
            model_last = exp;
            ch_req[exp] = 1'b0;
            for (int ch = 0; ch < NCH; ch++)
                if (ch != exp && ch_req[ch] == 1'b0 && $urandom_range(0, 1) == 1) begin
                    set_ch(ch, 1'($urandom_range(0, 1)), $urandom, $urandom); ch_req[ch] = 1'b1; end
            if (ch_req == '0) begin c = $urandom_range(0, NCH - 1); set_ch(c, 1'($urandom_range(0, 1)), $urandom, $urandom); ch_req[c] = 1'b1; end
        end
        ch_req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
        dif.dram_rd_fin = 1'b0; dif.dram_wr_fin = 1'b0; dif.dram_rd_data = '0;
        model_last = NCH - 1; model_rdata = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_timeout();
        test_race();
        test_ignore_fin();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
